divx_fx: RTL and testbench

//  Parametrised fixed-point divider: signed or unsigned (selectable per operation),

---
 rtl/divx_pkg.sv | 15 +
 rtl/divx_step.sv | 23 ++
 rtl/divx_fx.sv | 168 ++++++++++++++++
 tb/tb_divx_fx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/divx_pkg.sv
// Shared types and helpers for the fixed-point divider.
package divx_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int MAGW = 64;

  // Two's-complement magnitude of the low w bits of v; the most negative value maps to 2^(w-1).
  function automatic logic [MAGW-1:0] mag_of(input logic [MAGW-1:0] v, input int unsigned w);
    logic [MAGW-1:0] m;
    m = (MAGW'(1) << w) - MAGW'(1);
    return v[w-1] ? ((~v + MAGW'(1)) & m) : (v & m);
  endfunction

endpackage

// File: rtl/divx_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module divx_step #(
  parameter int WIDTH = 16,
  parameter int QW    = 24
) (
  input  logic [WIDTH:0]   acc,
  input  logic [QW-1:0]    quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   acc_next,
  output logic [QW-1:0]    quo_next
);

  logic [WIDTH+1:0] sh, df;
  logic             ge;

  // acc < dvs always holds, so sh fits WIDTH+1 bits and df's top bit is a clean borrow.
  assign sh       = {acc, quo[QW-1]};
  assign df       = sh - {2'b00, dvs};
  assign ge       = ~df[WIDTH+1];
  assign acc_next = ge ? df[WIDTH:0] : sh[WIDTH:0];
  assign quo_next = {quo[QW-2:0], ge};

endmodule

// File: rtl/divx_fx.sv
// Fixed-point signed/unsigned divider, STEPS quotient bits per cycle, saturating, tagged.
module divx_fx
  import divx_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FBITS     = 8,
  parameter int STEPS     = 1,
  parameter bit SIGNED_EN = 1'b1,
  parameter int TAGW      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [TAGW-1:0] out_tag,
  output logic            out_dbz,
  output logic            out_ovf,
  output logic            busy
);

  localparam int QW = WIDTH + FBITS;
  localparam int N  = QW / STEPS;
  localparam int CW = $clog2(N + 1);
  localparam logic [QW-1:0] NEG_MAX = QW'(1) << (WIDTH - 1);
  localparam logic [QW-1:0] POS_MAX = NEG_MAX - QW'(1);

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [TAGW-1:0]  tag;
    logic             dbz;
    logic             ovf;
  } rsp_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  acc;
  logic [QW-1:0]   quo;
  logic [WIDTH-1:0] dvs;
  logic            sgn_r, neg_r;
  logic [TAGW-1:0] tag_r;
  logic            vld_r;
  rsp_t            rsp_r;

  logic            accept, last, sgn_in;
  logic [WIDTH-1:0] ma, mb;

  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign last      = (state == CALC) && (cnt == CW'(N - 1));
  assign out_valid = vld_r;
  assign out_q     = rsp_r.q;
  assign out_tag   = rsp_r.tag;
  assign out_dbz   = rsp_r.dbz;
  assign out_ovf   = rsp_r.ovf;

  assign sgn_in = SIGNED_EN && in_signed;
  assign ma     = sgn_in ? WIDTH'(mag_of(MAGW'(in_a), WIDTH)) : in_a;
  assign mb     = sgn_in ? WIDTH'(mag_of(MAGW'(in_b), WIDTH)) : in_b;

  // STEPS restoring steps chained per clock
  logic [STEPS:0][WIDTH:0] acc_c;
  logic [STEPS:0][QW-1:0]  quo_c;
  assign acc_c[0] = acc;
  assign quo_c[0] = quo;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    divx_step #(.WIDTH(WIDTH), .QW(QW)) u_step (
      .acc      (acc_c[i]),
      .quo      (quo_c[i]),
      .dvs      (dvs),
      .acc_next (acc_c[i+1]),
      .quo_next (quo_c[i+1])
    );
  end

  // Sign application and saturation on the final magnitude
  logic [QW-1:0]    mag;
  logic [WIDTH-1:0] low, res_q;
  logic             res_ovf;
  assign mag = quo_c[STEPS];
  assign low = mag[WIDTH-1:0];

  always_comb begin
    res_ovf = 1'b0;
    res_q   = neg_r ? -low : low;
    if (!sgn_r) begin
      if ((mag >> WIDTH) != '0) begin
        res_ovf = 1'b1;
        res_q   = '1;
      end
    end else if (!neg_r && mag > POS_MAX) begin
      res_ovf = 1'b1;
      res_q   = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (neg_r && mag > NEG_MAX) begin
      res_ovf = 1'b1;
      res_q   = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (in_b == '0) ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (vld_r && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      quo   <= '0;
      dvs   <= '0;
      sgn_r <= 1'b0;
      neg_r <= 1'b0;
      tag_r <= '0;
      vld_r <= 1'b0;
      rsp_r <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= '0;
          acc   <= '0;
          quo   <= QW'(ma) << FBITS;
          dvs   <= mb;
          sgn_r <= sgn_in;
          neg_r <= sgn_in && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          tag_r <= in_tag;
        end
        CALC: begin
          acc <= acc_c[STEPS];
          quo <= quo_c[STEPS];
          cnt <= cnt + CW'(1);
          if (last) begin
            vld_r <= 1'b1;
            rsp_r <= '{q: res_q, tag: tag_r, dbz: 1'b0, ovf: res_ovf};
          end
        end
        DONE: begin
          // Entering DONE without a result means divide-by-zero; publish one cycle later.
          if (!vld_r) begin
            vld_r <= 1'b1;
            rsp_r <= '{q: '0, tag: tag_r, dbz: 1'b1, ovf: 1'b0};
          end else if (out_ready) begin
            vld_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divx_fx.sv
// Directed bench for divx_fx: WIDTH=8, FBITS=4, one instance with STEPS=1 and one with STEPS=2.
module tb_divx_fx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic       in_signed = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [3:0] in_tag = '0;

  logic       r1, ov1, d1, f1, b1, r2, ov2, d2, f2, b2;
  logic [7:0] q1, q2;
  logic [3:0] t1, t2;

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  divx_fx #(.WIDTH(8), .FBITS(4), .STEPS(1), .SIGNED_EN(1'b1), .TAGW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready),
    .out_q(q1), .out_tag(t1), .out_dbz(d1), .out_ovf(f1), .busy(b1));

  divx_fx #(.WIDTH(8), .FBITS(4), .STEPS(2), .SIGNED_EN(1'b1), .TAGW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov2), .out_ready(out_ready),
    .out_q(q2), .out_tag(t2), .out_dbz(d2), .out_ovf(f2), .busy(b2));

  // Issue one op, scramble the inputs after acceptance, wait (bounded) for the result, take it.
  task automatic run_op(input bit sel, input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] t, output logic [7:0] q, output logic dbz,
                        output logic ovf, output logic [3:0] tg, output int lat);
    @(negedge clk);
    in_signed = s; in_a = a; in_b = b; in_tag = t;
    if (sel) v2 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; v2 = 1'b0;
    in_signed = ~s; in_a = ~a; in_b = b ^ 8'h5A; in_tag = ~t;
    lat = 0;
    while (!(sel ? ov2 : ov1) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    q   = sel ? q2 : q1;
    dbz = sel ? d2 : d1;
    ovf = sel ? f2 : f1;
    tg  = sel ? t2 : t1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vec++; if (r1 !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %b, want 0", r1); end
    vec++; if (ov1 !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b, want 0", ov1); end
    vec++; if (b1 !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b, want 0", b1); end
    vec++; if ({q1, t1, d1, f1} !== 14'h0) begin errs++; $display("FAIL rst_outs: got %h, want 0", {q1, t1, d1, f1}); end
    @(negedge clk); rst_n = 1'b1; #1;
    vec++; if (r1 !== 1'b1) begin errs++; $display("FAIL rel_in_ready1: got %b, want 1", r1); end
    vec++; if (r2 !== 1'b1) begin errs++; $display("FAIL rel_in_ready2: got %b, want 1", r2); end
  endtask

  task automatic test_basic();
    logic [7:0] q; logic dz, ov; logic [3:0] tg; int lat;
    run_op(1'b0, 1'b0, 8'h60, 8'h20, 4'hA, q, dz, ov, tg, lat);
    vec++; if (q !== 8'h30) begin errs++; $display("FAIL basic_q: got %h, want 30", q); end
    vec++; if ({dz, ov} !== 2'b00) begin errs++; $display("FAIL basic_flags: got %b, want 00", {dz, ov}); end
    vec++; if (lat !== 12) begin errs++; $display("FAIL basic_lat: got %0d, want 12", lat); end
    vec++; if (tg !== 4'hA) begin errs++; $display("FAIL basic_tag: got %h, want a", tg); end
  endtask

  task automatic test_signed();
    logic [7:0] q; logic dz, ov; logic [3:0] tg; int lat;
    for (int s = 0; s < 2; s++) begin
      run_op(s[0], 1'b1, 8'hD0, 8'h20, 4'h1, q, dz, ov, tg, lat);
      vec++; if (q !== 8'hE8) begin errs++; $display("FAIL signed_q steps%0d: got %h, want e8", s + 1, q); end
      vec++; if (lat !== (s ? 6 : 12)) begin errs++; $display("FAIL signed_lat steps%0d: got %0d, want %0d", s + 1, lat, s ? 6 : 12); end
      run_op(s[0], 1'b0, 8'h10, 8'h30, 4'h2, q, dz, ov, tg, lat);
      vec++; if (q !== 8'h05) begin errs++; $display("FAIL trunc_q steps%0d: got %h, want 05", s + 1, q); end
      vec++; if (ov !== 1'b0) begin errs++; $display("FAIL trunc_ovf steps%0d: got %b, want 0", s + 1, ov); end
      vec++; if (lat !== (s ? 6 : 12)) begin errs++; $display("FAIL trunc_lat steps%0d: got %0d, want %0d", s + 1, lat, s ? 6 : 12); end
    end
  endtask

  task automatic test_dbz();
    logic [7:0] q; logic dz, ov; logic [3:0] tg; int lat;
    run_op(1'b0, 1'b0, 8'h55, 8'h00, 4'h7, q, dz, ov, tg, lat);
    vec++; if (lat !== 1) begin errs++; $display("FAIL dbz_lat: got %0d, want 1", lat); end
    vec++; if (dz !== 1'b1) begin errs++; $display("FAIL dbz_flag: got %b, want 1", dz); end
    vec++; if (q !== 8'h00) begin errs++; $display("FAIL dbz_q: got %h, want 00", q); end
    vec++; if (ov !== 1'b0) begin errs++; $display("FAIL dbz_ovf: got %b, want 0", ov); end
    vec++; if (tg !== 4'h7) begin errs++; $display("FAIL dbz_tag: got %h, want 7", tg); end
  endtask

  task automatic test_ovf();
    logic [7:0] q; logic dz, ov; logic [3:0] tg; int lat;
    run_op(1'b0, 1'b0, 8'hF0, 8'h08, 4'h3, q, dz, ov, tg, lat);
    vec++; if ({q, ov} !== {8'hFF, 1'b1}) begin errs++; $display("FAIL ovf_u: got q=%h ovf=%b, want q=ff ovf=1", q, ov); end
    run_op(1'b0, 1'b1, 8'h70, 8'hFF, 4'h4, q, dz, ov, tg, lat);
    vec++; if ({q, ov} !== {8'h80, 1'b1}) begin errs++; $display("FAIL ovf_s: got q=%h ovf=%b, want q=80 ovf=1", q, ov); end
    run_op(1'b0, 1'b1, 8'h80, 8'h10, 4'h5, q, dz, ov, tg, lat);
    vec++; if ({q, ov} !== {8'h80, 1'b0}) begin errs++; $display("FAIL ovf_bound: got q=%h ovf=%b, want q=80 ovf=0", q, ov); end
    run_op(1'b1, 1'b1, 8'h70, 8'hFF, 4'h4, q, dz, ov, tg, lat);
    vec++; if ({q, ov} !== {8'h80, 1'b1}) begin errs++; $display("FAIL ovf_s steps2: got q=%h ovf=%b, want q=80 ovf=1", q, ov); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    in_signed = 1'b0; in_a = 8'h60; in_b = 8'h20; in_tag = 4'h3; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    n = 0;
    while (!ov1 && n < 100) begin @(posedge clk); #1; n++; end
    vec++; if (ov1 !== 1'b1) begin errs++; $display("FAIL bp_wait: got out_valid=%b, want 1", ov1); end
    // Offer a second op while the first result is still held.
    in_a = 8'h10; in_b = 8'h30; in_tag = 4'h9; v1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vec++; if ({ov1, q1, t1} !== {1'b1, 8'h30, 4'h3}) begin errs++; $display("FAIL bp_hold c%0d: got v=%b q=%h t=%h, want v=1 q=30 t=3", c, ov1, q1, t1); end
      vec++; if ({r1, b1} !== 2'b01) begin errs++; $display("FAIL bp_ctl c%0d: got ready=%b busy=%b, want 0 1", c, r1, b1); end
    end
    @(negedge clk);
    v1 = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vec++; if ({ov1, b1, r1} !== 3'b001) begin errs++; $display("FAIL bp_release: got v=%b busy=%b ready=%b, want 0 0 1", ov1, b1, r1); end
    repeat (3) @(posedge clk); #1;
    vec++; if (b1 !== 1'b0) begin errs++; $display("FAIL bp_no_accept: got busy=%b, want 0", b1); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q; logic dz, ov; logic [3:0] tg; int lat; bit seen;
    @(negedge clk);
    in_signed = 1'b0; in_a = 8'hF0; in_b = 8'h08; in_tag = 4'h6; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++; if ({ov1, b1, r1} !== 3'b000) begin errs++; $display("FAIL mid_rst_ctl: got v=%b busy=%b ready=%b, want 0 0 0", ov1, b1, r1); end
    vec++; if ({q1, t1, d1, f1} !== 14'h0) begin errs++; $display("FAIL mid_rst_outs: got %h, want 0", {q1, t1, d1, f1}); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin @(posedge clk); #1; seen |= ov1; end
    vec++; if (seen !== 1'b0) begin errs++; $display("FAIL mid_rst_lost: got out_valid seen=%b, want 0", seen); end
    run_op(1'b0, 1'b0, 8'h60, 8'h20, 4'hC, q, dz, ov, tg, lat);
    vec++; if ({q, tg, dz, ov} !== {8'h30, 4'hC, 2'b00}) begin errs++; $display("FAIL mid_rst_next: got q=%h t=%h dbz=%b ovf=%b, want q=30 t=c 0 0", q, tg, dz, ov); end
    vec++; if (lat !== 12) begin errs++; $display("FAIL mid_rst_lat: got %0d, want 12", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_dbz();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
